mmu_dispatch_arbiter: RTL and testbench
=======================================

Name: mmu_dispatch_arbiter

Overview:
Parametrised request dispatcher between the alloc/free request FIFOs and the allocation datapath (fdt for alloc, or_tree for free). It validates page counts against a configurable maximum, encodes sizes as ceil(log2(pages)) and answers invalid requests directly into the response FIFOs. A weighted alloc/free arbiter with burst quotas, a free-backlog override and a programmable drain gap on every mode switch sits between the request FIFOs and the datapath. It also keeps a saturating reject counter.

Parameters:
ID_W, 8, request id width
IDX_W, 20, page index width
CNT_W, 4, page-count field width
SIZE_W, 3, encoded size width (must hold clog2(MAX_PAGES))
MAX_PAGES, 8, largest legal page count; power of two, <= 2^CNT_W-1
FIFO_CNT_W, 7, free FIFO occupancy width
FREE_THRESHOLD, 64, free occupancy forcing free mode
ALLOC_BURST, 4, max consecutive alloc grants while free pending
FREE_BURST, 4, max consecutive free grants while alloc pending
SWITCH_DRAIN, 5, idle cycles inserted on mode switch (0 allowed)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
alloc_req_pop  out  1  alloc FIFO pop (combinational)
alloc_req_id  in  ID_W  alloc FIFO head id, valid the cycle after pop
alloc_req_page_count  in  CNT_W  alloc FIFO head page count
alloc_fifo_empty  in  1  alloc FIFO empty
free_req_pop  out  1  free FIFO pop (combinational)
free_req_id  in  ID_W  free FIFO head id
free_req_page_idx  in  IDX_W  free FIFO head page index
free_req_page_count  in  CNT_W  free FIFO head page count
free_fifo_empty  in  1  free FIFO empty
free_fifo_data_count  in  FIFO_CNT_W  free FIFO occupancy
alloc_req_valid_fdt_out  out  1  one-cycle alloc issue pulse
alloc_req_id_fdt_out  out  ID_W  issued alloc id
alloc_req_size_fdt_out  out  SIZE_W  issued alloc size code
free_req_valid_or_tree_out  out  1  one-cycle free issue pulse
free_req_id_or_tree_out  out  ID_W  issued free id
free_req_page_idx_or_tree_out  out  IDX_W  issued free page index
free_req_size_or_tree_out  out  SIZE_W  issued free size code
alloc_rsp_write_en  out  1  alloc failure response write
alloc_rsp_id  out  ID_W  failed alloc id
alloc_rsp_fail_reason  out  2  1=zero pages, 2=over MAX_PAGES
alloc_rsp_fifo_almost_full  in  1  alloc response back-pressure
free_rsp_write_en  out  1  free failure response write
free_rsp_id  out  ID_W  failed free id
free_rsp_fail_reason  out  2  1=zero pages, 2=over MAX_PAGES
free_rsp_fifo_almost_full  in  1  free response back-pressure
fdt_blocked_fdt_in  in  1  fdt cannot accept alloc
mode_out  out  1  current mode, 0=alloc, 1=free
reject_count  out  16  saturating count of rejected requests

Behaviour:
- Reset: all outputs 0, including ids, sizes and indices; mode=alloc; state=SELECT; burst and drain counters 0.
- States: SELECT, POP, CHECK, DRAIN.
- Eligibility: alloc_ok = !alloc_fifo_empty & !fdt_blocked_fdt_in & !alloc_rsp_fifo_almost_full. free_ok = !free_fifo_empty & !free_rsp_fifo_almost_full.
- SELECT, target mode chosen in priority order:
  - Free, if free_ok & free_fifo_data_count >= FREE_THRESHOLD.
  - Otherwise current mode, if it is eligible and its burst count < its quota, or the other mode is ineligible.
  - Otherwise the other mode, if eligible.
  - If neither mode is eligible, stay in SELECT.
- SELECT exits:
  - Target == mode: go to POP.
  - Target != mode: set mode=target, clear burst count, load drain counter, go to DRAIN. If SWITCH_DRAIN==0, go straight to POP.
- DRAIN: counts down SWITCH_DRAIN cycles, then goes to POP. Eligibility is not re-sampled.
- POP: asserts the pop of the current mode for exactly one cycle, then goes to CHECK. Eligibility is rechecked here; if it has dropped, go to SELECT with no pop.
- CHECK: samples the head data.
  - count==0 → reason 1.
  - count > MAX_PAGES → reason 2.
  - A failure drives the response write_en/id/reason, registered, for one cycle; no issue; reject_count increments and saturates at 0xFFFF.
  - Otherwise: size = ceil(log2(count)) (1→0, 2→1, 3..4→2, 5..8→3); issue valid pulse next cycle with id/size (and page_idx for free); increment the mode's burst count, saturating at its quota.
  - Rejected requests do not consume quota.
  - Return to SELECT.
- Latency: pop at T, valid or rsp at T+2. Minimum spacing between issues is 3 cycles.
- Issued id, size and index registers hold their value until the next issue. Failure rsp id and reason return to 0 when not written.
- mode_out is registered and changes on entry to DRAIN.
- fdt_blocked_fdt_in rising during DRAIN: POP detects it and returns to SELECT.

Test Plan:
- Alloc only, counts 1,2,3,5,8, ids 0x10..0x14 → fdt pulses, sizes 0,1,2,3,3, each 2 cycles after its pop; no free activity.
- Alloc count 0 (id 0x21) and 9 (id 0x22) → alloc_rsp_write_en pulses with reasons 1 and 2; no fdt valid; reject_count=2.
- Both FIFOs hold 10 requests, occupancy <64, ALLOC_BURST=FREE_BURST=4 → grants 4 alloc, drain 5 cycles, 4 free, drain, ...; mode_out toggles accordingly.
- Alloc busy, free_fifo_data_count driven to 64 → next SELECT switches to free after the drain and issues until occupancy drops below 64 and the quota is reached.
- fdt_blocked_fdt_in=1 with free pending → switch to free, no alloc_req_pop asserted; deassert → alloc resumes after the drain.
- rst_n asserted during CHECK → all outputs 0 immediately, state SELECT, no pulse emitted after release.

Source files
------------

// File: rtl/mmu_dispatch_arbiter_if.sv
// Request, issue and failure-response bundle between the MMU request FIFOs,
// the dispatch arbiter (master) and the surrounding FIFOs/datapath (slave).
interface mmu_dispatch_arbiter_if #(
   parameter int ID_W       = 8,
   parameter int IDX_W      = 20,
   parameter int CNT_W      = 4,
   parameter int SIZE_W     = 3,
   parameter int FIFO_CNT_W = 7
);
   logic                  alloc_req_pop;
   logic [ID_W-1:0]       alloc_req_id;
   logic [CNT_W-1:0]      alloc_req_page_count;
   logic                  alloc_fifo_empty;
   logic                  free_req_pop;
   logic [ID_W-1:0]       free_req_id;
   logic [IDX_W-1:0]      free_req_page_idx;
   logic [CNT_W-1:0]      free_req_page_count;
   logic                  free_fifo_empty;
   logic [FIFO_CNT_W-1:0] free_fifo_data_count;
   logic                  alloc_req_valid_fdt_out;
   logic [ID_W-1:0]       alloc_req_id_fdt_out;
   logic [SIZE_W-1:0]     alloc_req_size_fdt_out;
   logic                  free_req_valid_or_tree_out;
   logic [ID_W-1:0]       free_req_id_or_tree_out;
   logic [IDX_W-1:0]      free_req_page_idx_or_tree_out;
   logic [SIZE_W-1:0]     free_req_size_or_tree_out;
   logic                  alloc_rsp_write_en;
   logic [ID_W-1:0]       alloc_rsp_id;
   logic [1:0]            alloc_rsp_fail_reason;
   logic                  alloc_rsp_fifo_almost_full;
   logic                  free_rsp_write_en;
   logic [ID_W-1:0]       free_rsp_id;
   logic [1:0]            free_rsp_fail_reason;
   logic                  free_rsp_fifo_almost_full;
   logic                  fdt_blocked_fdt_in;
   logic                  mode_out;
   logic [15:0]           reject_count;

   modport master (
      output alloc_req_pop, free_req_pop,
      output alloc_req_valid_fdt_out, alloc_req_id_fdt_out, alloc_req_size_fdt_out,
      output free_req_valid_or_tree_out, free_req_id_or_tree_out,
      output free_req_page_idx_or_tree_out, free_req_size_or_tree_out,
      output alloc_rsp_write_en, alloc_rsp_id, alloc_rsp_fail_reason,
      output free_rsp_write_en, free_rsp_id, free_rsp_fail_reason,
      output mode_out, reject_count,
      input  alloc_req_id, alloc_req_page_count, alloc_fifo_empty,
      input  free_req_id, free_req_page_idx, free_req_page_count,
      input  free_fifo_empty, free_fifo_data_count,
      input  alloc_rsp_fifo_almost_full, free_rsp_fifo_almost_full,
      input  fdt_blocked_fdt_in
   );

   modport slave (
      input  alloc_req_pop, free_req_pop,
      input  alloc_req_valid_fdt_out, alloc_req_id_fdt_out, alloc_req_size_fdt_out,
      input  free_req_valid_or_tree_out, free_req_id_or_tree_out,
      input  free_req_page_idx_or_tree_out, free_req_size_or_tree_out,
      input  alloc_rsp_write_en, alloc_rsp_id, alloc_rsp_fail_reason,
      input  free_rsp_write_en, free_rsp_id, free_rsp_fail_reason,
      input  mode_out, reject_count,
      output alloc_req_id, alloc_req_page_count, alloc_fifo_empty,
      output free_req_id, free_req_page_idx, free_req_page_count,
      output free_fifo_empty, free_fifo_data_count,
      output alloc_rsp_fifo_almost_full, free_rsp_fifo_almost_full,
      output fdt_blocked_fdt_in
   );
endinterface

// File: rtl/mmu_dispatch_arbiter.sv
// Weighted alloc/free request dispatcher: validates page counts, encodes sizes,
// rejects bad requests into the response FIFOs and drains on every mode switch.
module mmu_dispatch_arbiter #(
   parameter int ID_W           = 8,
   parameter int IDX_W          = 20,
   parameter int CNT_W          = 4,
   parameter int SIZE_W         = 3,
   parameter int MAX_PAGES      = 8,
   parameter int FIFO_CNT_W     = 7,
   parameter int FREE_THRESHOLD = 64,
   parameter int ALLOC_BURST    = 4,
   parameter int FREE_BURST     = 4,
   parameter int SWITCH_DRAIN   = 5
) (
   input logic                    clk,
   input logic                    rst_n,
   mmu_dispatch_arbiter_if.master bus
);
   localparam int   BURST_MAX  = (ALLOC_BURST > FREE_BURST) ? ALLOC_BURST : FREE_BURST;
   localparam int   BURST_W    = $clog2(BURST_MAX + 1);
   localparam int   DRAIN_W    = $clog2(SWITCH_DRAIN + 2);
   localparam logic MODE_ALLOC = 1'b0;
   localparam logic MODE_FREE  = 1'b1;

   typedef enum logic [1:0] {SELECT, POP, CHECK, DRAIN} state_t;

   state_t              state;
   logic                mode;
   logic [BURST_W-1:0]  burst_cnt;
   logic [DRAIN_W-1:0]  drain_cnt;

   logic                  alloc_ok, free_ok, free_urgent, cur_ok, oth_ok;
   logic                  want_valid, want_mode;
   logic [BURST_W-1:0]    quota;
   logic [CNT_W-1:0]      chk_count;
   logic [ID_W-1:0]       chk_id;
   logic [IDX_W-1:0]      chk_idx;
   logic [FIFO_CNT_W-1:0] free_occ;
   logic [1:0]            chk_reason;
   logic [SIZE_W-1:0]     chk_size;

   // ceil(log2(count)) for legal counts 1..MAX_PAGES
   function automatic logic [SIZE_W-1:0] size_code(input logic [CNT_W-1:0] count);
      logic [SIZE_W-1:0] s;
      s = '0;
      for (int i = 0; i < CNT_W; i++)
         if ((32'd1 << i) < 32'(count)) s = SIZE_W'(i + 1);
      return s;
   endfunction

   function automatic logic [1:0] fail_reason(input logic [CNT_W-1:0] count);
      if (count == '0) return 2'd1;
      if (32'(count) > MAX_PAGES) return 2'd2;
      return 2'd0;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic [BURST_W-1:0] sat_inc_burst(input logic [BURST_W-1:0] v,
                                                        input logic [BURST_W-1:0] lim);
      return (v >= lim) ? lim : v + BURST_W'(1);
   endfunction

   assign free_occ    = bus.free_fifo_data_count;
   assign alloc_ok    = !bus.alloc_fifo_empty && !bus.fdt_blocked_fdt_in && !bus.alloc_rsp_fifo_almost_full;
   assign free_ok     = !bus.free_fifo_empty && !bus.free_rsp_fifo_almost_full;
   assign free_urgent = free_ok && (32'(free_occ) >= FREE_THRESHOLD);
   assign cur_ok      = (mode == MODE_FREE) ? free_ok : alloc_ok;
   assign oth_ok      = (mode == MODE_FREE) ? alloc_ok : free_ok;
   assign quota       = (mode == MODE_FREE) ? BURST_W'(FREE_BURST) : BURST_W'(ALLOC_BURST);

   assign chk_count  = (mode == MODE_FREE) ? bus.free_req_page_count : bus.alloc_req_page_count;
   assign chk_id     = (mode == MODE_FREE) ? bus.free_req_id : bus.alloc_req_id;
   assign chk_idx    = bus.free_req_page_idx;
   assign chk_reason = fail_reason(chk_count);
   assign chk_size   = size_code(chk_count);

   // Backlog override first, then stick with the current mode while it has quota
   // or nothing else is waiting.
   always_comb begin
      want_valid = 1'b1;
      want_mode  = mode;
      if (free_urgent)                                 want_mode  = MODE_FREE;
      else if (cur_ok && ((burst_cnt < quota) || !oth_ok)) want_mode  = mode;
      else if (oth_ok)                                 want_mode  = !mode;
      else                                             want_valid = 1'b0;
   end

   assign bus.alloc_req_pop = (state == POP) && (mode == MODE_ALLOC) && alloc_ok;
   assign bus.free_req_pop  = (state == POP) && (mode == MODE_FREE) && free_ok;
   assign bus.mode_out      = mode;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state                             <= SELECT;
         mode                              <= MODE_ALLOC;
         burst_cnt                         <= '0;
         drain_cnt                         <= '0;
         bus.alloc_req_valid_fdt_out       <= 1'b0;
         bus.alloc_req_id_fdt_out          <= '0;
         bus.alloc_req_size_fdt_out        <= '0;
         bus.free_req_valid_or_tree_out    <= 1'b0;
         bus.free_req_id_or_tree_out       <= '0;
         bus.free_req_page_idx_or_tree_out <= '0;
         bus.free_req_size_or_tree_out     <= '0;
         bus.alloc_rsp_write_en            <= 1'b0;
         bus.alloc_rsp_id                  <= '0;
         bus.alloc_rsp_fail_reason         <= '0;
         bus.free_rsp_write_en             <= 1'b0;
         bus.free_rsp_id                   <= '0;
         bus.free_rsp_fail_reason          <= '0;
         bus.reject_count                  <= '0;
      end else begin
         bus.alloc_req_valid_fdt_out    <= 1'b0;
         bus.free_req_valid_or_tree_out <= 1'b0;
         bus.alloc_rsp_write_en         <= 1'b0;
         bus.alloc_rsp_id               <= '0;
         bus.alloc_rsp_fail_reason      <= '0;
         bus.free_rsp_write_en          <= 1'b0;
         bus.free_rsp_id                <= '0;
         bus.free_rsp_fail_reason       <= '0;
         case (state)
            SELECT: begin
               if (want_valid) begin
                  if (want_mode == mode) begin
                     state <= POP;
                  end else begin
                     mode      <= want_mode;
                     burst_cnt <= '0;
                     drain_cnt <= DRAIN_W'(SWITCH_DRAIN - 1);
                     state     <= (SWITCH_DRAIN == 0) ? POP : DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (drain_cnt == '0) state <= POP;
               else                 drain_cnt <= drain_cnt - DRAIN_W'(1);
            end
            POP: state <= cur_ok ? CHECK : SELECT;
            CHECK: begin
               state <= SELECT;
               if (chk_reason != 2'd0) begin
                  bus.reject_count <= sat_inc16(bus.reject_count);
                  if (mode == MODE_FREE) begin
                     bus.free_rsp_write_en    <= 1'b1;
                     bus.free_rsp_id          <= chk_id;
                     bus.free_rsp_fail_reason <= chk_reason;
                  end else begin
                     bus.alloc_rsp_write_en    <= 1'b1;
                     bus.alloc_rsp_id          <= chk_id;
                     bus.alloc_rsp_fail_reason <= chk_reason;
                  end
               end else begin
                  burst_cnt <= sat_inc_burst(burst_cnt, quota);
                  if (mode == MODE_FREE) begin
                     bus.free_req_valid_or_tree_out    <= 1'b1;
                     bus.free_req_id_or_tree_out       <= chk_id;
                     bus.free_req_page_idx_or_tree_out <= chk_idx;
                     bus.free_req_size_or_tree_out     <= chk_size;
                  end else begin
                     bus.alloc_req_valid_fdt_out <= 1'b1;
                     bus.alloc_req_id_fdt_out    <= chk_id;
                     bus.alloc_req_size_fdt_out  <= chk_size;
                  end
               end
            end
            default: state <= SELECT;
         endcase
      end
   end
endmodule

// File: tb/tb_mmu_dispatch_arbiter.sv
// Randomized bench for mmu_dispatch_arbiter: queue-based FIFO environment and a
// timestamp-driven reference of the grant/drain/issue schedule.
module tb_mmu_dispatch_arbiter;
   localparam int ID_W           = 8;
   localparam int IDX_W          = 20;
   localparam int CNT_W          = 4;
   localparam int SIZE_W         = 3;
   localparam int MAX_PAGES      = 8;
   localparam int FIFO_CNT_W     = 7;
   localparam int FREE_THRESHOLD = 64;
   localparam int ALLOC_BURST    = 4;
   localparam int FREE_BURST     = 4;
   localparam int SWITCH_DRAIN   = 5;

   typedef struct packed {
      logic [ID_W-1:0]  id;
      logic [IDX_W-1:0] idx;
      logic [CNT_W-1:0] cnt;
   } req_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mmu_dispatch_arbiter_if #(.ID_W(ID_W), .IDX_W(IDX_W), .CNT_W(CNT_W), .SIZE_W(SIZE_W),
                             .FIFO_CNT_W(FIFO_CNT_W)) bus ();

   mmu_dispatch_arbiter #(
      .ID_W(ID_W), .IDX_W(IDX_W), .CNT_W(CNT_W), .SIZE_W(SIZE_W), .MAX_PAGES(MAX_PAGES),
      .FIFO_CNT_W(FIFO_CNT_W), .FREE_THRESHOLD(FREE_THRESHOLD), .ALLOC_BURST(ALLOC_BURST),
      .FREE_BURST(FREE_BURST), .SWITCH_DRAIN(SWITCH_DRAIN)
   ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int   n_total = 0;
   int   n_bad   = 0;
   int   cyc     = 0;
   req_t qa[$];
   req_t qf[$];
   int   p_block, p_afull, p_force, p_push, cnt_lo, cnt_hi;
   bit   pa_seen, pf_seen, rel_pending, rst_req, did_rst;
   int   seen_sizes[$];
   int   n_apop;

   // reference schedule: cycle numbers of the next select / pop / check
   int   t_sel, t_pop, t_chk;
   bit   m_mode;
   int   m_burst;
   req_t m_item;
   bit   ea_pop, ef_pop;
   logic e_av, e_fv, e_awe, e_fwe, e_mode;
   logic [ID_W-1:0]   e_aid, e_fid, e_arid, e_frid;
   logic [SIZE_W-1:0] e_asz, e_fsz;
   logic [IDX_W-1:0]  e_fidx;
   logic [1:0]        e_arr, e_frr;
   int   e_rej;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_total++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   function automatic bit pct(input int p);
      return ($urandom_range(0, 99) < p);
   endfunction

   function automatic int ceil_log2(input int n);
      int p = 1;
      int s = 0;
      while (p < n) begin
         p = p * 2;
         s++;
      end
      return s;
   endfunction

   function automatic int quota_of(input bit md);
      return md ? FREE_BURST : ALLOC_BURST;
   endfunction

   function automatic req_t rand_req();
      req_t r;
      r.id  = ID_W'($urandom);
      r.idx = IDX_W'($urandom);
      r.cnt = CNT_W'($urandom_range(cnt_lo, cnt_hi));
      return r;
   endfunction

   function automatic req_t mk_req(input int id, input int cnt);
      req_t r;
      r.id  = ID_W'(id);
      r.idx = IDX_W'($urandom);
      r.cnt = CNT_W'(cnt);
      return r;
   endfunction

   function automatic void model_reset();
      t_sel = -1; t_pop = -1; t_chk = -1;
      m_mode = 1'b0; m_burst = 0;
      ea_pop = 1'b0; ef_pop = 1'b0;
      e_av = 1'b0; e_aid = '0; e_asz = '0;
      e_fv = 1'b0; e_fid = '0; e_fidx = '0; e_fsz = '0;
      e_awe = 1'b0; e_arid = '0; e_arr = '0;
      e_fwe = 1'b0; e_frid = '0; e_frr = '0;
      e_mode = 1'b0; e_rej = 0;
   endfunction

   task automatic check_regs(input string pfx);
      check({pfx, "_fdt"}, 64'({bus.alloc_req_valid_fdt_out, bus.alloc_req_id_fdt_out, bus.alloc_req_size_fdt_out}),
            64'({e_av, e_aid, e_asz}));
      check({pfx, "_or_tree"}, 64'({bus.free_req_valid_or_tree_out, bus.free_req_id_or_tree_out,
                                   bus.free_req_page_idx_or_tree_out, bus.free_req_size_or_tree_out}),
            64'({e_fv, e_fid, e_fidx, e_fsz}));
      check({pfx, "_alloc_rsp"}, 64'({bus.alloc_rsp_write_en, bus.alloc_rsp_id, bus.alloc_rsp_fail_reason}),
            64'({e_awe, e_arid, e_arr}));
      check({pfx, "_free_rsp"}, 64'({bus.free_rsp_write_en, bus.free_rsp_id, bus.free_rsp_fail_reason}),
            64'({e_fwe, e_frid, e_frr}));
      check({pfx, "_mode"}, 64'(bus.mode_out), 64'(e_mode));
      check({pfx, "_reject"}, 64'(bus.reject_count), 64'(e_rej));
   endtask

   // Advances the reference by one cycle: this cycle's pops, next cycle's registered outputs.
   task automatic model_step();
      int reason, sz;
      bit a_ok, f_ok, cur, oth, tgt_valid, tgt;
      a_ok = (qa.size() != 0) && !bus.fdt_blocked_fdt_in && !bus.alloc_rsp_fifo_almost_full;
      f_ok = (qf.size() != 0) && !bus.free_rsp_fifo_almost_full;
      ea_pop = 1'b0; ef_pop = 1'b0;
      e_av = 1'b0; e_fv = 1'b0;
      e_awe = 1'b0; e_arid = '0; e_arr = '0;
      e_fwe = 1'b0; e_frid = '0; e_frr = '0;
      if (cyc == t_chk) begin
         reason = (m_item.cnt == 0) ? 1 : (int'(m_item.cnt) > MAX_PAGES) ? 2 : 0;
         if (reason != 0) begin
            if (e_rej < 65535) e_rej++;
            if (m_mode) begin e_fwe = 1'b1; e_frid = m_item.id; e_frr = 2'(reason); end
            else        begin e_awe = 1'b1; e_arid = m_item.id; e_arr = 2'(reason); end
         end else begin
            sz = ceil_log2(int'(m_item.cnt));
            if (m_mode) begin e_fv = 1'b1; e_fid = m_item.id; e_fidx = m_item.idx; e_fsz = SIZE_W'(sz); end
            else        begin e_av = 1'b1; e_aid = m_item.id; e_asz = SIZE_W'(sz); end
            if (m_burst < quota_of(m_mode)) m_burst++;
         end
         t_sel = cyc + 1;
      end
      if (cyc == t_pop) begin
         if (m_mode ? f_ok : a_ok) begin
            if (m_mode) begin ef_pop = 1'b1; m_item = qf[0]; end
            else        begin ea_pop = 1'b1; m_item = qa[0]; end
            t_chk = cyc + 1;
         end else begin
            t_sel = cyc + 1;
         end
      end
      if (cyc == t_sel) begin
         cur = m_mode ? f_ok : a_ok;
         oth = m_mode ? a_ok : f_ok;
         tgt_valid = 1'b1;
         tgt = m_mode;
         if (f_ok && int'(bus.free_fifo_data_count) >= FREE_THRESHOLD) tgt = 1'b1;
         else if (cur && (m_burst < quota_of(m_mode) || !oth))           tgt = m_mode;
         else if (oth)                                                  tgt = !m_mode;
         else                                                           tgt_valid = 1'b0;
         if (!tgt_valid)          t_sel = cyc + 1;
         else if (tgt == m_mode)  t_pop = cyc + 1;
         else begin
            m_mode = tgt; m_burst = 0; e_mode = tgt;
            t_pop = cyc + 1 + SWITCH_DRAIN;
         end
      end
   endtask

   task automatic step();
      req_t r;
      @(negedge clk);
      cyc++;
      if (rel_pending) begin
         rst_n = 1'b1; rel_pending = 1'b0; t_sel = cyc;
      end
      if (pa_seen && qa.size() != 0) begin
         r = qa.pop_front();
         bus.alloc_req_id = r.id; bus.alloc_req_page_count = r.cnt;
      end
      if (pf_seen && qf.size() != 0) begin
         r = qf.pop_front();
         bus.free_req_id = r.id; bus.free_req_page_idx = r.idx; bus.free_req_page_count = r.cnt;
      end
      if (pct(p_push) && qa.size() < 40) qa.push_back(rand_req());
      if (pct(p_push) && qf.size() < 40) qf.push_back(rand_req());
      bus.fdt_blocked_fdt_in         = pct(p_block);
      bus.alloc_rsp_fifo_almost_full = pct(p_afull);
      bus.free_rsp_fifo_almost_full  = pct(p_afull);
      bus.free_fifo_data_count = pct(p_force) ? FIFO_CNT_W'(FREE_THRESHOLD + $urandom_range(0, 63))
                                              : FIFO_CNT_W'(qf.size());
      bus.alloc_fifo_empty = (qa.size() == 0);
      bus.free_fifo_empty  = (qf.size() == 0);
      #1;
      if (rst_req && cyc == t_chk) begin
         rst_n = 1'b0;
         #1;
         model_reset();
         check_regs("rst_in_check");
         check("rst_in_check_pop", 64'({bus.alloc_req_pop, bus.free_req_pop}), 64'(0));
         pa_seen = 1'b0; pf_seen = 1'b0;
         rel_pending = 1'b1; rst_req = 1'b0; did_rst = 1'b1;
      end else begin
         check_regs("cyc");
         model_step();
         check("pop", 64'({bus.alloc_req_pop, bus.free_req_pop}), 64'({ea_pop, ef_pop}));
         pa_seen = bus.alloc_req_pop;
         pf_seen = bus.free_req_pop;
         if (bus.alloc_req_valid_fdt_out) seen_sizes.push_back(int'(bus.alloc_req_size_fdt_out));
         if (bus.alloc_req_pop) n_apop++;
      end
   endtask

   task automatic run_idle(input int maxc);
      int n = 0;
      while ((qa.size() != 0 || qf.size() != 0 || t_pop >= cyc || t_chk >= cyc) && n < maxc) begin
         step();
         n++;
      end
      check("drain_left", 64'(qa.size() + qf.size()), 64'(0));
      repeat (6) step();
   endtask

   int exp_sz[5] = '{0, 1, 2, 3, 3};
   int a_cnt[5]  = '{1, 2, 3, 5, 8};

   initial begin
      rst_n = 1'b0;
      bus.alloc_req_id = '0; bus.alloc_req_page_count = '0; bus.alloc_fifo_empty = 1'b1;
      bus.free_req_id = '0; bus.free_req_page_idx = '0; bus.free_req_page_count = '0;
      bus.free_fifo_empty = 1'b1; bus.free_fifo_data_count = '0;
      bus.alloc_rsp_fifo_almost_full = 1'b0; bus.free_rsp_fifo_almost_full = 1'b0;
      bus.fdt_blocked_fdt_in = 1'b0;
      p_block = 0; p_afull = 0; p_force = 0; p_push = 0; cnt_lo = 1; cnt_hi = 8;
      pa_seen = 1'b0; pf_seen = 1'b0; rst_req = 1'b0; did_rst = 1'b0; n_apop = 0;
      model_reset();
      repeat (3) @(negedge clk);
      #1;
      check_regs("reset");
      check("reset_pop", 64'({bus.alloc_req_pop, bus.free_req_pop}), 64'(0));
      rel_pending = 1'b1;

      // alloc only, legal counts
      for (int i = 0; i < 5; i++) qa.push_back(mk_req(8'h10 + i, a_cnt[i]));
      run_idle(200);
      check("alloc_only_issues", 64'(seen_sizes.size()), 64'(5));
      for (int i = 0; i < 5 && i < seen_sizes.size(); i++)
         check("alloc_only_size", 64'(seen_sizes[i]), 64'(exp_sz[i]));

      // zero and oversized counts
      qa.push_back(mk_req(8'h21, 0));
      qa.push_back(mk_req(8'h22, 9));
      run_idle(100);
      check("reject_total", 64'(bus.reject_count), 64'(2));
      check("reject_no_issue", 64'(seen_sizes.size()), 64'(5));

      // both FIFOs loaded, weighted bursts with drains
      for (int i = 0; i < 10; i++) begin qa.push_back(rand_req()); qf.push_back(rand_req()); end
      run_idle(600);

      // free backlog override
      for (int i = 0; i < 10; i++) begin qa.push_back(rand_req()); qf.push_back(rand_req()); end
      p_force = 100;
      repeat (30) step();
      p_force = 0;
      run_idle(600);

      // fdt blocked with free pending
      p_block = 100;
      n_apop = 0;
      for (int i = 0; i < 4; i++) begin qa.push_back(rand_req()); qf.push_back(rand_req()); end
      repeat (60) step();
      check("blocked_alloc_pops", 64'(n_apop), 64'(0));
      check("blocked_free_left", 64'(qf.size()), 64'(0));
      p_block = 0;
      run_idle(300);

      // random traffic with an async reset landing in CHECK
      p_push = 30; cnt_lo = 0; cnt_hi = 15; p_block = 20; p_afull = 10; p_force = 15;
      rst_req = 1'b1;
      repeat (800) step();
      check("reset_in_check_hit", 64'(did_rst), 64'(1));
      p_push = 0; p_block = 0; p_afull = 0; p_force = 0;
      run_idle(1500);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
